ysyx_25040105_exec_ctrl: RTL and testbench

//   Multi-cycle sequencer for the ysyx_25040105 core. It steps each instruction through fetch, decode, execute, memory and writeback.
//   It drives the IFU/LSU request handshakes, the IR latch, PC and register-file write enables, and the halt logic (ebreak, illegal, timeout).
//   It also keeps the cycle and retired-instruction counters. It sits between the IFU/LSU and the decoder/ALU/regfile datapath.

---
 rtl/ysyx_25040105_pkg.sv | 18 +
 rtl/ysyx_25040105_perf_cnt.sv | 21 ++
 rtl/ysyx_25040105_exec_ctrl.sv | 100 ++++++++++
 tb/tb_ysyx_25040105_exec_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040105_pkg.sv
// ysyx_25040105_pkg: sequencer state encoding and halt codes shared by the core control blocks
package ysyx_25040105_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;
  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;
  function automatic logic is_active(input state_t s);
    return s != S_IDLE && s != S_HALT;
  endfunction
endpackage

// File: rtl/ysyx_25040105_perf_cnt.sv
// ysyx_25040105_perf_cnt: free-running cycle and retired-instruction counters, wrapping modulo 2^CNT_W
module ysyx_25040105_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_inc,
  input  logic             ret_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (cyc_inc) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (ret_inc) instret <= instret + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ysyx_25040105_exec_ctrl.sv
// ysyx_25040105_exec_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer with handshake timeout and halt logic
module ysyx_25040105_exec_ctrl
  import ysyx_25040105_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ifu_req,
  input  logic             ifu_rvalid,
  output logic             ir_en,
  input  logic             dec_reg_wen,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_ebreak,
  input  logic             dec_illegal,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ack,
  output logic             pc_wen,
  output logic             rf_wen,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);
  state_t          st;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout;
  // Timeout fires on the cycle whose increment would make the count reach TIMEOUT, so a handshake in that same cycle still wins.
  assign timeout = wait_cnt == TO_W'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      wait_cnt  <= '0;
      halt_code <= HALT_EBREAK;
    end else begin
      case (st)
        S_IDLE: begin
          wait_cnt <= '0;
          if (start) st <= S_IF;
        end
        S_IF: begin
          wait_cnt <= wait_cnt + TO_W'(1);
          if (ifu_rvalid) st <= S_ID;
          else if (timeout) begin
            st        <= S_HALT;
            halt_code <= HALT_TIMEOUT;
          end
        end
        S_ID: begin
          if (dec_is_ebreak) begin
            st        <= S_HALT;
            halt_code <= HALT_EBREAK;
          end else if (dec_illegal) begin
            st        <= S_HALT;
            halt_code <= HALT_ILLEGAL;
          end else st <= S_EX;
        end
        S_EX: begin
          wait_cnt <= '0;
          st       <= (dec_is_load | dec_is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          wait_cnt <= wait_cnt + TO_W'(1);
          if (lsu_ack) st <= S_WB;
          else if (timeout) begin
            st        <= S_HALT;
            halt_code <= HALT_TIMEOUT;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          st       <= S_IF;
        end
        default: st <= S_HALT;
      endcase
    end
  end
  assign state   = st;
  assign halt    = st == S_HALT;
  assign ifu_req = st == S_IF;
  assign ir_en   = ifu_req & ifu_rvalid;
  assign lsu_req = st == S_MEM;
  assign lsu_we  = lsu_req & dec_is_store;
  assign pc_wen  = st == S_WB;
  assign rf_wen  = pc_wen & dec_reg_wen & ~dec_is_store;
  ysyx_25040105_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk      (clk),
    .rst      (rst),
    .cyc_inc  (is_active(st)),
    .ret_inc  (pc_wen),
    .cycle_cnt(cycle_cnt),
    .instret  (instret)
  );
endmodule

// File: tb/tb_ysyx_25040105_exec_ctrl.sv
// tb_ysyx_25040105_exec_ctrl: directed checks of the sequencer flows, halts, timeouts and async reset
module tb_ysyx_25040105_exec_ctrl;
  logic        clk = 0, rst = 1, start = 0;
  logic        ifu_rvalid = 0, lsu_ack = 0;
  logic        dec_reg_wen = 0, dec_is_load = 0, dec_is_store = 0, dec_is_ebreak = 0, dec_illegal = 0;
  logic        ifu_req, ir_en, lsu_req, lsu_we, pc_wen, rf_wen, halt;
  logic [1:0]  halt_code;
  logic [2:0]  state;
  logic [63:0] cycle_cnt, instret;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  ysyx_25040105_exec_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ir_en(ir_en),
    .dec_reg_wen(dec_reg_wen), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal), .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_ack(lsu_ack), .pc_wen(pc_wen), .rf_wen(rf_wen), .halt(halt), .halt_code(halt_code),
    .state(state), .cycle_cnt(cycle_cnt), .instret(instret)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic clear_dec();
    {dec_reg_wen, dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal} = '0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    start = 0; ifu_rvalid = 0; lsu_ack = 0;
    clear_dec();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_cyc", cycle_cnt, 0);
    chk("rst_ret", instret, 0);
    chk("rst_halt", {halt, halt_code, ifu_req, lsu_req, pc_wen}, 0);
    rst = 0;
    // ADDI
    start = 1; ifu_rvalid = 1; dec_reg_wen = 1;
    tick(); start = 0; settle();
    chk("addi_if", state, 1);
    chk("addi_if_req", {ifu_req, ir_en, pc_wen, rf_wen}, 4'b1100);
    tick(); chk("addi_id", state, 2);
    chk("addi_id_strb", {ifu_req, ir_en, pc_wen, rf_wen}, 0);
    tick(); chk("addi_ex", state, 3);
    tick(); chk("addi_wb", state, 5);
    chk("addi_wb_strb", {pc_wen, rf_wen}, 2'b11);
    tick(); chk("addi_next_if", state, 1);
    chk("addi_ret", instret, 1);
    chk("addi_cyc", cycle_cnt, 4);
    // load, ack in the third MEM cycle
    dec_is_load = 1;
    tick(); tick();
    chk("ld_ex", state, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) lsu_ack = 1;
      settle();
      chk("ld_mem_state", state, 4);
      chk("ld_mem_req", {lsu_req, lsu_we}, 2'b10);
    end
    tick(); lsu_ack = 0; settle();
    chk("ld_wb", state, 5);
    chk("ld_wb_rf", rf_wen, 1);
    tick();
    chk("ld_ret", instret, 2);
    chk("ld_cyc", cycle_cnt, 11);
    // store with reg_wen set must not write the regfile
    dec_is_load = 0; dec_is_store = 1;
    tick(); tick(); tick(); lsu_ack = 1; settle();
    chk("st_mem", state, 4);
    chk("st_we", {lsu_req, lsu_we}, 2'b11);
    tick(); lsu_ack = 0; settle();
    chk("st_wb", {pc_wen, rf_wen}, 2'b10);
    tick();
    chk("st_ret", instret, 3);
    chk("st_cyc", cycle_cnt, 16);
    // ebreak outranks illegal
    dec_is_store = 0; dec_is_ebreak = 1; dec_illegal = 1;
    tick(); chk("eb_id", state, 2);
    tick();
    chk("eb_state", state, 6);
    chk("eb_halt", {halt, halt_code}, 3'b100);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("eb_quiet", {ifu_req, lsu_req, pc_wen, rf_wen, ir_en}, 0);
    end
    chk("eb_ret", instret, 3);
    chk("eb_cyc", cycle_cnt, 18);
    chk("eb_sticky", {state, halt_code}, {3'd6, 2'd0});
    // illegal alone
    do_reset();
    chk("rst2_state", state, 0);
    start = 1; ifu_rvalid = 1; dec_illegal = 1;
    tick(); start = 0;
    tick(); tick();
    chk("ill_halt", {halt, halt_code, state}, {1'b1, 2'd1, 3'd6});
    chk("ill_ret", instret, 0);
    // fetch timeout after four empty IF cycles
    do_reset();
    start = 1;
    tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_if", state, 1);
      tick();
    end
    chk("to_halt", {halt, halt_code, state}, {1'b1, 2'd2, 3'd6});
    // handshake on the last allowed cycle wins
    do_reset();
    start = 1;
    tick(); start = 0;
    tick(); tick(); tick();
    ifu_rvalid = 1; settle();
    chk("to_win_ir", ir_en, 1);
    tick(); ifu_rvalid = 0; dec_is_load = 1; settle();
    chk("to_win_id", {halt, state}, {1'b0, 3'd2});
    tick(); tick();
    chk("rm_mem", lsu_req, 1);
    // async reset mid-MEM
    #2 rst = 1; #1;
    chk("arst_req", lsu_req, 0);
    chk("arst_state", state, 0);
    chk("arst_cnt", {cycle_cnt, instret}, 0);
    tick(); rst = 0; clear_dec();
    start = 1; ifu_rvalid = 1; dec_reg_wen = 1;
    tick(); start = 0; settle();
    chk("re_if", {state, ir_en}, {3'd1, 1'b1});
    tick(); tick(); tick();
    chk("re_wb", {state, rf_wen}, {3'd5, 1'b1});
    tick();
    chk("re_ret", instret, 1);
    chk("re_cyc", cycle_cnt, 4);
    // memory timeout
    dec_reg_wen = 0; dec_is_load = 1;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("mto_mem", state, 4);
      tick();
    end
    chk("mto_halt", {halt, halt_code, state}, {1'b1, 2'd2, 3'd6});
    chk("mto_ret", instret, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
